icache_dm: RTL and testbench

Direct-mapped instruction cache for the RISC-V Lite fetch path, between the program counter and the instruction-fetch control FSM. Each cycle it looks up the current PC, returns the instruction and a `match_o` hit flag, and on a miss refills the whole line from instruction memory through a single-outstanding request/valid handshake. The cache is read-only from the core side and holds no dirty state.

---
 rtl/icache_dm_pkg.sv | 13 +
 rtl/icache_dm_data_array.sv | 27 ++
 rtl/icache_dm.sv | 175 +++++++++++++++++
 tb/tb_icache_dm.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM state
// encoding and the instruction word size in bytes.
package my_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    COMMIT
  } ICACHE_states;

  localparam int unsigned ICACHE_WORD_BYTES = 4;

endpackage

// File: rtl/icache_dm_data_array.sv
// Register-based line storage for icache_dm: whole-line write, asynchronous
// single-word read.
module icache_data_array #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic                       clk,
  input  logic                       we_i,
  input  logic [$clog2(LINES)-1:0]   widx_i,
  input  logic [WORDS*32-1:0]        wline_i,
  input  logic [$clog2(LINES)-1:0]   ridx_i,
  input  logic [$clog2(WORDS)-1:0]   roff_i,
  output logic [31:0]                rdata_o
);

  logic [WORDS*32-1:0] mem_q [LINES];

  // Payload only; line validity is tracked by the owner, so no reset here.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[widx_i] <= wline_i;
    end
  end

  assign rdata_o = mem_q[ridx_i][roff_i*32 +: 32];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with whole-line refill over a single
// outstanding request/valid handshake. Define ICACHE_PERF_EN for hit/miss counters.
module icache_dm
  import my_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  input  logic        flush_i,
  output logic        match_o,
  output logic [31:0] instr_o,
  output logic        busy_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(LINES);
  localparam int BYTE_W = $clog2(ICACHE_WORD_BYTES);
  localparam int TAG_W  = 32 - BYTE_W - OFF_W - IDX_W;
  localparam int LINE_W = WORDS * 32;

  ICACHE_states          state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [LINES*TAG_W-1:0] tag_q, tag_d;
  logic [31:0]           line_base_q, line_base_d;
  logic [OFF_W-1:0]      cnt_q, cnt_d;
  logic [LINE_W-1:0]     lbuf_q, lbuf_d;
  logic                  commit_we;

  logic [OFF_W-1:0]      pc_off;
  logic [IDX_W-1:0]      pc_idx;
  logic [TAG_W-1:0]      pc_tag;
  logic [IDX_W-1:0]      fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  hit;
  logic [31:0]           word_rdata;
  logic                  unused_pc_bits;

  assign pc_off         = pc_i[BYTE_W +: OFF_W];
  assign pc_idx         = pc_i[BYTE_W+OFF_W +: IDX_W];
  assign pc_tag         = pc_i[31 -: TAG_W];
  assign unused_pc_bits = ^pc_i[BYTE_W-1:0];

  // The fill target comes from the latched base, not the live PC.
  assign fill_idx = line_base_q[BYTE_W+OFF_W +: IDX_W];
  assign fill_tag = line_base_q[31 -: TAG_W];

  assign hit     = valid_q[pc_idx] & (tag_q[pc_idx*TAG_W +: TAG_W] == pc_tag);
  assign match_o = pc_valid_i & (state_q == IDLE) & hit;
  // Gating on the valid bit keeps the unreset payload off the output.
  assign instr_o = ((state_q == IDLE) && valid_q[pc_idx]) ? word_rdata : '0;
  assign busy_o  = (state_q != IDLE);

  assign mem_req_o  = (state_q == REFILL);
  assign mem_addr_o = (state_q == REFILL) ? line_base_q + (32'(cnt_q) << BYTE_W) : '0;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    line_base_d = line_base_q;
    cnt_d       = cnt_q;
    lbuf_d      = lbuf_q;
    commit_we   = 1'b0;

    if (flush_i) begin
      valid_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (!flush_i && pc_valid_i && !hit) begin
          line_base_d = {pc_i[31:BYTE_W+OFF_W], {(BYTE_W+OFF_W){1'b0}}};
          cnt_d       = '0;
          state_d     = REFILL;
        end
      end
      REFILL: begin
        if (flush_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (mem_rvalid_i) begin
          lbuf_d[cnt_q*32 +: 32] = mem_rdata_i;
          cnt_d                  = cnt_q + 1'b1;
          if (cnt_q == OFF_W'(WORDS-1)) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (!flush_i) begin
          commit_we                          = 1'b1;
          tag_d[fill_idx*TAG_W +: TAG_W]     = fill_tag;
          valid_d[fill_idx]                  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      line_base_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      line_base_q <= line_base_d;
      cnt_q       <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    lbuf_q <= lbuf_d;
  end

  icache_data_array #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_data (
    .clk     (clk),
    .we_i    (commit_we),
    .widx_i  (fill_idx),
    .wline_i (lbuf_q),
    .ridx_i  (pc_idx),
    .roff_i  (pc_off),
    .rdata_o (word_rdata)
  );

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        miss_start;

  assign miss_start = (state_q == IDLE) && (state_d == REFILL);

  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'b0, match_o};
    miss_cnt_d = miss_cnt_q + {31'b0, miss_start};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm with a configurable wait-state
// memory model returning addr ^ 0xA5A5A5A5.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        flush_i;
  logic        match_o;
  logic [31:0] instr_o;
  logic        busy_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        mem_rvalid_i;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  int   n_pass   = 0;
  int   n_total  = 0;
  int   wait_cfg = 0;
  int   wait_cnt = 0;
  logic mem_en   = 1'b0;
  logic late_rv  = 1'b0;
  int   ncyc;

  icache_dm #(
    .LINES (16),
    .WORDS (4)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .pc_i         (pc_i),
    .pc_valid_i   (pc_valid_i),
    .flush_i      (flush_i),
    .match_o      (match_o),
    .instr_o      (instr_o),
    .busy_o       (busy_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_rvalid_i (mem_rvalid_i)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  assign mem_rvalid_i = late_rv | (mem_en & mem_req_o & (wait_cnt == wait_cfg));
  assign mem_rdata_i  = mem_addr_o ^ 32'hA5A5A5A5;

  always @(posedge clk) begin
    if (mem_en && mem_req_o) wait_cnt <= (wait_cnt == wait_cfg) ? 0 : wait_cnt + 1;
    else                     wait_cnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts negedges from the current one until match_o, bounded by max_cyc.
  task automatic wait_match(input int max_cyc, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!match_o && n < max_cyc);
  endtask

  initial begin
    rstn       = 1'b0;
    pc_i       = '0;
    pc_valid_i = 1'b0;
    flush_i    = 1'b0;
    #3;
    check("rst_match", match_o, 0);
    check("rst_instr", instr_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_req", mem_req_o, 0);
    check("rst_addr", mem_addr_o, 0);
    tick();
    rstn = 1'b1;

    // Cold miss at 0x100, zero-wait memory
    tick();
    pc_i = 32'h100; pc_valid_i = 1'b1; mem_en = 1'b1; wait_cfg = 0;
    @(negedge clk);
    check("cold_miss_match", match_o, 0);
    check("cold_miss_busy", busy_o, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("refill_req", mem_req_o, 1);
      check("refill_addr", mem_addr_o, 32'h100 + 32'(4*k));
    end
    @(negedge clk);
    check("commit_busy", busy_o, 1);
    check("commit_req", mem_req_o, 0);
    @(negedge clk);
    check("cyc6_match", match_o, 1);
    check("cyc6_instr", instr_o, 32'hA5A5A4A5);
    check("cyc6_busy", busy_o, 0);

    // Hits within the installed line
    tick();
    pc_i = 32'h108;
    @(negedge clk);
    check("hit108_match", match_o, 1);
    check("hit108_instr", instr_o, 32'hA5A5A4AD);
    check("hit108_req", mem_req_o, 0);
    tick();
    pc_i = 32'h10C;
    @(negedge clk);
    check("hit10c_instr", instr_o, 32'hA5A5A4A9);

    // Conflict on index 0
    tick();
    pc_i = 32'h200;
    @(negedge clk);
    check("conf200_match", match_o, 0);
    wait_match(40, ncyc);
    check("conf200_cycles", ncyc, 6);
    check("conf200_instr", instr_o, 32'hA5A5A7A5);
    tick();
    pc_i = 32'h100;
    @(negedge clk);
    check("back100_match", match_o, 0);
    wait_match(40, ncyc);
    check("back100_cycles", ncyc, 6);
    check("back100_instr", instr_o, 32'hA5A5A4A5);

    // Three wait states per word
    tick();
    pc_i = 32'h340; wait_cfg = 3;
    @(negedge clk);
    check("ws_miss_match", match_o, 0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("ws_req", mem_req_o, 1);
      check("ws_addr", mem_addr_o, 32'h340 + 32'(4*(k/4)));
    end
    @(negedge clk);
    check("ws_commit_busy", busy_o, 1);
    @(negedge clk);
    check("ws_match", match_o, 1);
    check("ws_instr", instr_o, 32'hA5A5A6E5);

    // Flush beats a miss in the same IDLE cycle
    tick();
    wait_cfg = 0; pc_i = 32'h700; flush_i = 1'b1;
    @(negedge clk);
    check("flprio_match", match_o, 0);
    tick();
    flush_i = 1'b0; pc_valid_i = 1'b0;
    @(negedge clk);
    check("flprio_busy", busy_o, 0);

    // Flush during the second refill word
    tick();
    pc_i = 32'h500; pc_valid_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("fl_word0_addr", mem_addr_o, 32'h500);
    tick();
    flush_i = 1'b1;
    @(negedge clk);
    check("fl_word1_addr", mem_addr_o, 32'h504);
    tick();
    flush_i = 1'b0; pc_valid_i = 1'b0; late_rv = 1'b1;
    @(negedge clk);
    check("fl_abort_busy", busy_o, 0);
    check("fl_abort_req", mem_req_o, 0);
    tick();
    late_rv = 1'b0;
    @(negedge clk);
    check("fl_late_busy", busy_o, 0);
    tick();
    pc_i = 32'h100; pc_valid_i = 1'b1;
    @(negedge clk);
    check("fl_100_match", match_o, 0);
    @(negedge clk);
    check("fl_100_addr", mem_addr_o, 32'h100);
    wait_match(40, ncyc);
    check("fl_100_cycles", ncyc, 5);

`ifdef ICACHE_PERF_EN
    tick();
    rstn = 1'b0; pc_valid_i = 1'b0;
    @(negedge clk);
    check("perf_rst_hit", hit_cnt_o, 0);
    check("perf_rst_miss", miss_cnt_o, 0);
    tick();
    rstn = 1'b1; pc_i = 32'h100; pc_valid_i = 1'b1;
    @(negedge clk);
    wait_match(40, ncyc);
    repeat (10) @(posedge clk);
    #1;
    pc_valid_i = 1'b0;
    @(negedge clk);
    check("perf_miss", miss_cnt_o, 1);
    check("perf_hit", hit_cnt_o, 10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
